// File: rtl/exec_seq_ctrl_if.sv
// Host load stream into the execution sequencer: one word per handshake,
// routed by in_sel to o1/o2/w1/w2.
interface exec_seq_ctrl_if #(
    parameter int OP_SIZE = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_sel;
    logic [OP_SIZE-1:0] in_data;

    modport master (output in_valid, in_sel, in_data, input in_ready);
    modport slave  (input in_valid, in_sel, in_data, output in_ready);
endinterface

// File: rtl/exec_seq_ctrl.sv
// Sequencer for the two-lane MAC datapath: loads operand/weight vectors,
// runs the pop/accumulate pass, drains the PE chain and writes the sum to o1.
module exec_seq_ctrl #(
    parameter int OP_SIZE  = 32,
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               rewind,
    input  logic               two_lay,
    input  logic [LEN_W-1:0]   vec_len,
    exec_seq_ctrl_if.slave     host,
    input  logic               computation_end,
    output logic               r,
    output logic               e,
    output logic               o1,
    output logic               o2,
    output logic               w1,
    output logic               w2,
    output logic               reset,
    output logic               next,
    output logic [OP_SIZE-1:0] op,
    output logic               busy,
    output logic               done,
    output logic               err
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, WB, DONE} state_t;
    typedef struct packed {
        logic r, e, o1, o2, w1, w2, reset, next;
    } strb_t;

    state_t                  state_q, state_d;
    strb_t                   strb_q, strb_d;
    logic [OP_SIZE-1:0]      op_q, op_d;
    logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                    rdy_q, rdy_d, lay2_q, lay2_d;
    logic [LEN_W-1:0]        len_q, len_d, run_cnt_q, run_cnt_d;
    // Load counters indexed by in_sel: 0=o1, 1=o2, 2=w1, 3=w2
    logic [3:0][LEN_W-1:0]   cnt_q, cnt_d, quota;
    logic [3:0]              full;
    logic                    hs, last_push;

    assign hs = host.in_valid & rdy_q;

    always_comb begin
        quota[0]  = len_q;
        quota[1]  = lay2_q ? len_q : '0;
        quota[2]  = len_q;
        quota[3]  = lay2_q ? len_q : '0;
        last_push = 1'b1;
        for (int k = 0; k < 4; k++) begin
            full[k] = (cnt_q[k] == quota[k]);
            if (k == int'(host.in_sel))
                last_push = last_push & ((cnt_q[k] + LEN_W'(1)) == quota[k]);
            else
                last_push = last_push & full[k];
        end
    end

    always_comb begin
        state_d   = state_q;
        strb_d    = '0;
        op_d      = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rdy_d     = 1'b0;
        len_d     = len_q;
        lay2_d    = lay2_q;
        run_cnt_d = run_cnt_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // A zero-length job or an unconsumed previous result is refused
                    if (vec_len == '0 || !computation_end) begin
                        err_d = 1'b1;
                    end else begin
                        len_d     = vec_len;
                        lay2_d    = two_lay;
                        cnt_d     = '0;
                        run_cnt_d = '0;
                        rdy_d     = 1'b1;
                        state_d   = LOAD;
                    end
                end else if (rewind) begin
                    strb_d.reset = 1'b1;
                    strb_d.o1    = 1'b1;
                    strb_d.o2    = lay2_q;
                end
            end
            LOAD: begin
                rdy_d = 1'b1;
                if (hs) begin
                    if (full[host.in_sel]) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d[host.in_sel] = cnt_q[host.in_sel] + LEN_W'(1);
                        op_d = host.in_data;
                        case (host.in_sel)
                            2'd0:    strb_d.o1 = 1'b1;
                            2'd1:    strb_d.o2 = 1'b1;
                            2'd2:    strb_d.w1 = 1'b1;
                            default: strb_d.w2 = 1'b1;
                        endcase
                        if (last_push) begin
                            rdy_d     = 1'b0;
                            run_cnt_d = '0;
                            state_d   = RUN;
                        end
                    end
                end
            end
            RUN: begin
                strb_d.r  = 1'b1;
                strb_d.o1 = 1'b1;
                strb_d.w1 = 1'b1;
                strb_d.o2 = lay2_q;
                strb_d.w2 = lay2_q;
                // First pop restarts the accumulator instead of adding to feedback
                strb_d.e  = (run_cnt_q == '0);
                if (run_cnt_q == len_q - LEN_W'(1)) begin
                    run_cnt_d = '0;
                    state_d   = DRAIN;
                end else begin
                    run_cnt_d = run_cnt_q + LEN_W'(1);
                end
            end
            DRAIN: begin
                if (run_cnt_q == LEN_W'(PIPE_LAT - 1)) begin
                    run_cnt_d = '0;
                    state_d   = WB;
                end else begin
                    run_cnt_d = run_cnt_q + LEN_W'(1);
                end
            end
            WB: begin
                strb_d.e  = 1'b1;
                strb_d.o1 = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                done_d      = 1'b1;
                strb_d.next = 1'b1;
                strb_d.o1   = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d   = IDLE;
            strb_d    = '0;
            op_d      = '0;
            rdy_d     = 1'b0;
            done_d    = 1'b0;
            err_d     = (state_q != IDLE);
            cnt_d     = '0;
            run_cnt_d = '0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            strb_q    <= '0;
            op_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
            lay2_q    <= 1'b0;
            len_q     <= '0;
            run_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            strb_q    <= strb_d;
            op_q      <= op_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdy_q     <= rdy_d;
            lay2_q    <= lay2_d;
            len_q     <= len_d;
            run_cnt_q <= run_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign r             = strb_q.r;
    assign e             = strb_q.e;
    assign o1            = strb_q.o1;
    assign o2            = strb_q.o2;
    assign w1            = strb_q.w1;
    assign w2            = strb_q.w2;
    assign reset         = strb_q.reset;
    assign next          = strb_q.next;
    assign op            = op_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign host.in_ready = rdy_q;
endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Directed bench for exec_seq_ctrl: cycle-exact strobe checks plus a push
// scoreboard fed when host words are driven and drained by a strobe monitor.
module tb_exec_seq_ctrl;
    localparam int OP_SIZE  = 32;
    localparam int LEN_W    = 8;
    localparam int PIPE_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start, abort, rewind, two_lay, computation_end;
    logic [LEN_W-1:0] vec_len;
    logic r, e, o1, o2, w1, w2, reset, next, busy, done, err;
    logic [OP_SIZE-1:0] op;

    exec_seq_ctrl_if #(.OP_SIZE(OP_SIZE)) hif ();

    exec_seq_ctrl #(.OP_SIZE(OP_SIZE), .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rewind(rewind),
        .two_lay(two_lay), .vec_len(vec_len), .host(hif),
        .computation_end(computation_end),
        .r(r), .e(e), .o1(o1), .o2(o2), .w1(w1), .w2(w2), .reset(reset), .next(next),
        .op(op), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]         sel;
        logic [OP_SIZE-1:0] data;
    } push_t;

    push_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] strb;
    assign strb = {r, e, o1, o2, w1, w2, reset, next};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every push strobe must match the oldest accepted host word
    push_t      mon_p;
    logic [3:0] mon_oh;
    always @(negedge clk) begin
        if (rst && !r && !e && !reset && !next && (o1 | o2 | w1 | w2)) begin
            if (exp_q.size() == 0) begin
                chk("push_unexpected", {o1, o2, w1, w2}, 0);
            end else begin
                mon_p  = exp_q.pop_front();
                mon_oh = 4'b1000 >> mon_p.sel;
                chk("push", {{o1, o2, w1, w2}, op}, {mon_oh, mon_p.data});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [1:0] sel, input logic [31:0] d, input bit acc,
                        output int waits);
        waits = 0;
        hif.in_valid = 1'b1;
        hif.in_sel   = sel;
        hif.in_data  = d;
        while (hif.in_ready !== 1'b1 && waits < 16) begin
            tick();
            waits++;
        end
        if (acc) exp_q.push_back(push_t'({sel, d}));
        tick();
        hif.in_valid = 1'b0;
    endtask

    task automatic run_tail(input logic lay2, input int len);
        for (int i = 0; i < len; i++) begin
            tick();
            chk("run_strb", strb, {1'b1, (i == 0), 1'b1, lay2, 1'b1, lay2, 2'b00});
        end
        for (int i = 0; i < PIPE_LAT; i++) begin
            tick();
            chk("drain", {busy, strb}, {1'b1, 8'h00});
        end
        tick();
        chk("wb", {busy, done, strb}, {2'b10, 8'b0110_0000});
        tick();
        chk("done", {done, strb}, {1'b1, 8'b0010_0001});
        tick();
        chk("idle", {busy, done, strb}, 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        int w;
        start = 0; abort = 0; rewind = 0; two_lay = 0; vec_len = 0; computation_end = 1;
        hif.in_valid = 0; hif.in_sel = 0; hif.in_data = 0;

        rst = 0;
        repeat (3) tick();
        chk("rst_outs", {strb, busy, done, err, hif.in_ready, op}, 0);
        rst = 1;
        tick();
        chk("post_rst", {strb, busy, done, err, hif.in_ready, op}, 0);

        // single lane, len 2
        start = 1; two_lay = 0; vec_len = 2;
        tick();
        start = 0;
        chk("t1_load", {busy, hif.in_ready, strb}, {2'b11, 8'h00});
        send(2'd0, 32'd5, 1, w); chk("t1_wait", w, 0);
        send(2'd2, 32'd7, 1, w); chk("t1_wait", w, 0);
        send(2'd0, 32'd3, 1, w); chk("t1_wait", w, 0);
        send(2'd2, 32'd2, 1, w); chk("t1_wait", w, 0);
        chk("t1_rdy_drop", hif.in_ready, 0);
        run_tail(1'b0, 2);

        // two lanes, len 3, valid held high
        start = 1; two_lay = 1; vec_len = 3;
        tick();
        start = 0;
        for (int i = 0; i < 12; i++) begin
            send(2'(i % 4), 32'(100 + i), 1, w);
            chk("t2_ready_held", w, 0);
        end
        chk("t2_rdy_drop", hif.in_ready, 0);
        run_tail(1'b1, 3);
        rewind = 1;
        tick();
        rewind = 0;
        chk("t2_rewind_l2", strb, 8'b0011_0010);
        tick();
        chk("t2_rewind_1cyc", strb, 0);

        // lane-2 word while lane 2 disabled
        start = 1; two_lay = 0; vec_len = 1;
        tick();
        start = 0;
        send(2'd0, 32'h11, 1, w);
        send(2'd1, 32'h22, 0, w);
        chk("t3_err", {err, strb}, {1'b1, 8'h00});
        chk("t3_ready", hif.in_ready, 1);
        send(2'd2, 32'h33, 1, w);
        chk("t3_err_clr", err, 0);
        run_tail(1'b0, 1);

        // rejected starts
        start = 1; vec_len = 0;
        tick();
        start = 0;
        chk("t4_len0", {err, busy, hif.in_ready}, 3'b100);
        tick();
        chk("t4_len0_pulse", {err, busy}, 0);
        computation_end = 0; start = 1; vec_len = 2;
        tick();
        start = 0;
        chk("t4_cend", {err, busy, hif.in_ready}, 3'b100);
        tick();
        chk("t4_cend_idle", {err, busy}, 0);
        computation_end = 1;

        // abort during RUN, then rewind
        start = 1; two_lay = 0; vec_len = 4;
        tick();
        start = 0;
        for (int i = 0; i < 8; i++) send(2'((i % 2) * 2), 32'(200 + i), 1, w);
        tick();
        chk("t5_run0", strb, 8'b1110_1000);
        abort = 1;
        tick();
        abort = 0;
        chk("t5_abort", {busy, done, err, hif.in_ready, strb}, {4'b0010, 8'h00});
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5_quiet", {done, err, strb}, 0);
        end
        rewind = 1;
        tick();
        rewind = 0;
        chk("t5_rewind", strb, 8'b0010_0010);
        tick();
        chk("t5_rewind_1cyc", strb, 0);
        chk("sb_final", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
